// File: rtl/cordic_phase_frontend.sv
// Full-circle sin/cos wrapper around a pipelined CORDIC rotator: quadrant range reduction in, quadrant rotation out.
// Latency: 1 cycle accept->cord_start, 1 cycle cord_done->out_valid (end-to-end 1 + rotator latency + 1).
// Backpressure: in_ready drops when the rotator is not ready or the tag FIFO is full; no output backpressure.
module cordic_phase_frontend #(
    parameter int                          BIT_WIDTH      = 32,
    parameter logic signed [BIT_WIDTH-1:0] K              = 32'sd1304052707,
    parameter int                          TAG_DEPTH      = 64,
    parameter int                          LOG2_TAG_DEPTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] phase,
    output logic                 cord_start,
    output logic [BIT_WIDTH-1:0] cord_angle,
    output logic [BIT_WIDTH-1:0] cord_x,
    output logic [BIT_WIDTH-1:0] cord_y,
    input  logic                 cord_ready,
    input  logic [BIT_WIDTH-1:0] cord_out_x,
    input  logic [BIT_WIDTH-1:0] cord_out_y,
    input  logic                 cord_done,
    output logic                 out_valid,
    output logic [BIT_WIDTH-1:0] out_cos,
    output logic [BIT_WIDTH-1:0] out_sin,
    output logic [1:0]           out_quadrant,
    output logic                 tag_err
);

    // Half a quadrant: added before truncation so the quadrant index rounds to the nearest axis.
    localparam logic [BIT_WIDTH-1:0]      ROUND_HALF = BIT_WIDTH'(1) << (BIT_WIDTH - 3);
    localparam logic [BIT_WIDTH-1:0]      POS_MAX    = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0]      NEG_MIN    = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0]      DATA_ONE   = BIT_WIDTH'(1);
    localparam logic [LOG2_TAG_DEPTH:0]   FULL_CNT   = (LOG2_TAG_DEPTH+1)'(TAG_DEPTH);
    localparam logic [LOG2_TAG_DEPTH:0]   CNT_ONE    = (LOG2_TAG_DEPTH+1)'(1);
    localparam logic [LOG2_TAG_DEPTH-1:0] PTR_ONE    = LOG2_TAG_DEPTH'(1);

    // Two's complement negate that maps the most negative value to the most positive one.
    function automatic logic [BIT_WIDTH-1:0] sat_neg(input logic [BIT_WIDTH-1:0] v);
        return (v == NEG_MIN) ? POS_MAX : (~v + DATA_ONE);
    endfunction

    logic                      cord_start_q, cord_start_d;
    logic [BIT_WIDTH-1:0]      cord_angle_q, cord_angle_d;
    logic                      out_valid_q, out_valid_d;
    logic [BIT_WIDTH-1:0]      out_cos_q, out_cos_d;
    logic [BIT_WIDTH-1:0]      out_sin_q, out_sin_d;
    logic [1:0]                out_quadrant_q, out_quadrant_d;
    logic                      tag_err_q, tag_err_d;
    logic [LOG2_TAG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_TAG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2_TAG_DEPTH:0]   count_q, count_d;
    logic [1:0]                tag_mem_q [TAG_DEPTH];

    logic                 cnt_full;
    logic                 cnt_empty;
    logic                 push;
    logic                 pop;
    logic [1:0]           q_new;
    logic [BIT_WIDTH-1:0] residual;
    logic [1:0]           pop_tag;

    assign cord_x       = K;
    assign cord_y       = '0;
    assign cord_start   = cord_start_q;
    assign cord_angle   = cord_angle_q;
    assign out_valid    = out_valid_q;
    assign out_cos      = out_cos_q;
    assign out_sin      = out_sin_q;
    assign out_quadrant = out_quadrant_q;
    assign tag_err      = tag_err_q;

    // Handshake and FIFO occupancy; in_ready looks only at registered count, so a same-cycle pop cannot raise it.
    always_comb begin
        cnt_full  = (count_q == FULL_CNT);
        cnt_empty = (count_q == '0);
        in_ready  = ~reset & cord_ready & ~cnt_full;
        push      = in_valid & in_ready;
        pop       = cord_done & ~cnt_empty;
        pop_tag   = tag_mem_q[rd_ptr_q];
    end

    // Range reduction: nearest quadrant axis plus a residual in [-pi/4, pi/4), rescaled to rotator units.
    always_comb begin
        q_new        = 2'((phase + ROUND_HALF) >> (BIT_WIDTH - 2));
        residual     = phase - {q_new, {(BIT_WIDTH-2){1'b0}}};
        cord_start_d = push;
        cord_angle_d = cord_angle_q;
        if (push) begin
            cord_angle_d = residual << 1;
        end
    end

    // Tag FIFO pointer and count bookkeeping; sticky error on a result with no outstanding tag.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tag_err_d = tag_err_q | (cord_done & cnt_empty);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Quadrant rotation of the rotator result using the tag popped alongside it; outputs hold otherwise.
    always_comb begin
        out_valid_d    = pop;
        out_cos_d      = out_cos_q;
        out_sin_d      = out_sin_q;
        out_quadrant_d = out_quadrant_q;
        if (pop) begin
            out_quadrant_d = pop_tag;
            case (pop_tag)
                2'd0: begin
                    out_cos_d = cord_out_x;
                    out_sin_d = cord_out_y;
                end
                2'd1: begin
                    out_cos_d = sat_neg(cord_out_y);
                    out_sin_d = cord_out_x;
                end
                2'd2: begin
                    out_cos_d = sat_neg(cord_out_x);
                    out_sin_d = sat_neg(cord_out_y);
                end
                default: begin
                    out_cos_d = cord_out_y;
                    out_sin_d = sat_neg(cord_out_x);
                end
            endcase
        end
    end

    // Control and output registers with synchronous reset; in-flight tags are discarded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cord_start_q   <= 1'b0;
            cord_angle_q   <= '0;
            out_valid_q    <= 1'b0;
            out_cos_q      <= '0;
            out_sin_q      <= '0;
            out_quadrant_q <= 2'd0;
            tag_err_q      <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            cord_start_q   <= cord_start_d;
            cord_angle_q   <= cord_angle_d;
            out_valid_q    <= out_valid_d;
            out_cos_q      <= out_cos_d;
            out_sin_q      <= out_sin_d;
            out_quadrant_q <= out_quadrant_d;
            tag_err_q      <= tag_err_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // Tag storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= q_new;
        end
    end

endmodule

// File: tb/tb_cordic_phase_frontend.sv
// Self-checking bench for cordic_phase_frontend with a bench-side rotator model.
// Latency: checks 1-cycle launch and 1-cycle result registration.
// Backpressure: exercises cord_ready stalls and tag FIFO full.
module tb_cordic_phase_frontend;

    localparam logic [31:0] KV = 32'd1304052707;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] phase;
    logic        cord_start;
    logic [31:0] cord_angle;
    logic [31:0] cord_x;
    logic [31:0] cord_y;
    logic        cord_ready;
    logic [31:0] cord_out_x;
    logic [31:0] cord_out_y;
    logic        cord_done;
    logic        out_valid;
    logic [31:0] out_cos;
    logic [31:0] out_sin;
    logic [1:0]  out_quadrant;
    logic        tag_err;

    int vectors     = 0;
    int miscompares = 0;

    cordic_phase_frontend dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .phase(phase),
        .cord_start(cord_start), .cord_angle(cord_angle), .cord_x(cord_x), .cord_y(cord_y),
        .cord_ready(cord_ready), .cord_out_x(cord_out_x), .cord_out_y(cord_out_y),
        .cord_done(cord_done), .out_valid(out_valid), .out_cos(out_cos), .out_sin(out_sin),
        .out_quadrant(out_quadrant), .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: nearest quadrant axis of the full-turn phase, by plain integer arithmetic.
    function automatic int m_quad(input logic [31:0] p);
        longint t;
        t = (longint'({32'd0, p}) + 64'sd536870912) / 64'sd1073741824;
        return int'(t % 4);
    endfunction

    // Reference: residual angle (phase minus quadrant axis) as a signed value, doubled.
    function automatic logic [31:0] m_angle(input logic [31:0] p);
        longint r;
        r = longint'({32'd0, p}) - longint'(m_quad(p)) * 64'sd1073741824;
        if (r >= 64'sd2147483648)  r = r - 64'sd4294967296;
        if (r < -64'sd2147483648)  r = r + 64'sd4294967296;
        return 32'(r * 2);
    endfunction

    function automatic logic [31:0] m_neg(input logic [31:0] v);
        longint n;
        n = -longint'($signed(v));
        if (n > 64'sd2147483647) n = 64'sd2147483647;
        return 32'(n);
    endfunction

    // Reference: rotate (cos r, sin r) by q quarter turns.
    task automatic m_rot(input int q, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] c, output logic [31:0] s);
        case (q)
            0:       begin c = x;        s = y;        end
            1:       begin c = m_neg(y); s = x;        end
            2:       begin c = m_neg(x); s = m_neg(y); end
            default: begin c = y;        s = m_neg(x); end
        endcase
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Drives one isolated request and one rotator answer, returning what was observed.
    task automatic run_one(input logic [31:0] p, input logic [31:0] x, input logic [31:0] y,
                           output logic rdy, output logic st, output logic [31:0] ang,
                           output logic st2, output logic ov, output logic [31:0] oc,
                           output logic [31:0] os, output logic [1:0] oq,
                           output logic ov2, output logic [31:0] oc2);
        in_valid = 1'b1;
        phase    = p;
        #1;
        rdy = in_ready;
        tick;
        st  = cord_start;
        ang = cord_angle;
        in_valid = 1'b0;
        tick;
        st2 = cord_start;
        cord_done  = 1'b1;
        cord_out_x = x;
        cord_out_y = y;
        tick;
        ov = out_valid;
        oc = out_cos;
        os = out_sin;
        oq = out_quadrant;
        cord_done  = 1'b0;
        cord_out_x = $urandom;
        cord_out_y = $urandom;
        tick;
        ov2 = out_valid;
        oc2 = out_cos;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; cord_ready = 1'b1; cord_done = 1'b0;
        phase = 32'h1234_5678; cord_out_x = '0; cord_out_y = '0;
        tick;
        tick;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        vectors++;
        if ({cord_start, cord_angle, out_valid, out_cos, out_sin, out_quadrant, tag_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs start=%b ang=%h ov=%b cos=%h sin=%h q=%0d err=%b want all 0",
                     cord_start, cord_angle, out_valid, out_cos, out_sin, out_quadrant, tag_err);
        end
        vectors++;
        if (cord_x !== KV || cord_y !== 32'd0) begin
            miscompares++; $display("FAIL reset_consts x=%h y=%h want %h 0", cord_x, cord_y, KV);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
        end
        tick;
    endtask

    task automatic test_quadrants;
        logic [31:0] ph[4], xs[4], ys[4], ec[4], es[4];
        logic [1:0]  eq[4];
        logic        rdy, st, st2, ov, ov2;
        logic [31:0] ang, oc, os, oc2;
        logic [1:0]  oq;
        ph = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        xs = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h8000_0000, 32'h1234_5678};
        ys = '{32'h0000_0000, 32'h0000_0000, 32'h0000_1234, 32'h0000_ABCD};
        ec = '{32'h7FFF_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_ABCD};
        es = '{32'h0000_0000, 32'h7FFF_0000, 32'hFFFF_EDCC, 32'hEDCB_A988};
        eq = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 4; i++) begin
            run_one(ph[i], xs[i], ys[i], rdy, st, ang, st2, ov, oc, os, oq, ov2, oc2);
            vectors++;
            if ({rdy, st, st2} !== 3'b110) begin
                miscompares++; $display("FAIL quad[%0d] launch rdy/start/start_next got %b want 110", i, {rdy, st, st2});
            end
            vectors++;
            if (ang !== 32'd0) begin
                miscompares++; $display("FAIL quad[%0d] angle got %h want 0", i, ang);
            end
            vectors++;
            if (ov !== 1'b1 || oq !== eq[i]) begin
                miscompares++; $display("FAIL quad[%0d] valid/quadrant got %b/%0d want 1/%0d", i, ov, oq, eq[i]);
            end
            vectors++;
            if (oc !== ec[i] || os !== es[i]) begin
                miscompares++; $display("FAIL quad[%0d] cos/sin got %h/%h want %h/%h", i, oc, os, ec[i], es[i]);
            end
            vectors++;
            if (ov2 !== 1'b0 || oc2 !== ec[i]) begin
                miscompares++; $display("FAIL quad[%0d] hold valid/cos got %b/%h want 0/%h", i, ov2, oc2, ec[i]);
            end
        end
    endtask

    task automatic test_boundaries;
        logic [31:0] ph[5], ea[5];
        logic [1:0]  eq[5];
        logic        rdy, st, st2, ov, ov2;
        logic [31:0] ang, oc, os, oc2, c, s;
        logic [1:0]  oq;
        ph = '{32'h2000_0000, 32'hE000_0000, 32'hFFFF_FFFF, 32'h5FFF_FFFF, 32'h6000_0000};
        ea = '{32'hC000_0000, 32'hC000_0000, 32'hFFFF_FFFE, 32'h3FFF_FFFE, 32'hC000_0000};
        eq = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
        for (int i = 0; i < 5; i++) begin
            run_one(ph[i], 32'h1111_1111, 32'h2222_2222, rdy, st, ang, st2, ov, oc, os, oq, ov2, oc2);
            m_rot(int'(eq[i]), 32'h1111_1111, 32'h2222_2222, c, s);
            vectors++;
            if (st !== 1'b1 || ang !== ea[i]) begin
                miscompares++; $display("FAIL bound[%0d] start/angle got %b/%h want 1/%h", i, st, ang, ea[i]);
            end
            vectors++;
            if (ov !== 1'b1 || oq !== eq[i] || oc !== c || os !== s) begin
                miscompares++;
                $display("FAIL bound[%0d] result got v=%b q=%0d %h/%h want v=1 q=%0d %h/%h", i, ov, oq, oc, os, eq[i], c, s);
            end
        end
    endtask

    task automatic test_fifo_full;
        int n;
        cord_ready = 1'b1; cord_done = 1'b0; phase = 32'h0; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++; $display("FAIL fill[%0d] in_ready got %b want 1", i, in_ready);
            end
            tick;
        end
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL full in_ready got %b want 0", in_ready);
        end
        tick;
        vectors++;
        if (cord_start !== 1'b0) begin
            miscompares++; $display("FAIL full_no_launch cord_start got %b want 0", cord_start);
        end
        in_valid = 1'b0; cord_done = 1'b1; cord_out_x = 32'h7FFF_0000; cord_out_y = 32'h0;
        tick;
        cord_done = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL full_pop valid/in_ready got %b/%b want 1/1", out_valid, in_ready);
        end
        in_valid = 1'b1; cord_done = 1'b1;
        tick;
        cord_done = 1'b0;
        #1;
        vectors++;
        if (cord_start !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL push_pop start/valid/in_ready got %b/%b/%b want 1/1/1", cord_start, out_valid, in_ready);
        end
        tick;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL refill in_ready got %b want 0", in_ready);
        end
        n = 0;
        cord_done = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick;
            if (out_valid === 1'b1 && out_quadrant === 2'd0 && out_cos === 32'h7FFF_0000) n++;
        end
        cord_done = 1'b0;
        vectors++;
        if (n !== 64 || tag_err !== 1'b0) begin
            miscompares++; $display("FAIL drain results got %0d err=%b want 64 err=0", n, tag_err);
        end
        tick;
    endtask

    task automatic test_tag_err;
        cord_done = 1'b1;
        tick;
        cord_done = 1'b0;
        vectors++;
        if (tag_err !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL empty_done err/valid got %b/%b want 1/0", tag_err, out_valid);
        end
        tick;
        tick;
        vectors++;
        if (tag_err !== 1'b1) begin
            miscompares++; $display("FAIL err_sticky got %b want 1", tag_err);
        end
        do_reset;
        tick;
        vectors++;
        if (tag_err !== 1'b0) begin
            miscompares++; $display("FAIL err_cleared got %b want 0", tag_err);
        end
    endtask

    task automatic test_random;
        logic [1:0]  tag_q[$];
        int          launch_q[$];
        logic [31:0] bnd[5];
        logic [31:0] x, y, c, s, exp_ang;
        int          issued, popped, cnt, cyc, last_rdy, t;
        logic        er, acc, pp;
        logic [1:0]  pq;
        bnd = '{32'h2000_0000, 32'hE000_0000, 32'hFFFF_FFFF, 32'h9FFF_FFFF, 32'h6000_0000};
        issued = 0; popped = 0; cnt = 0; cyc = 0; last_rdy = 0;
        x = '0; y = '0; pq = 2'd0; exp_ang = '0;
        while (popped < 300 && cyc < 5000) begin
            cord_ready = ($urandom_range(0, 7) != 0);
            in_valid   = (issued < 300) && ($urandom_range(0, 3) != 0);
            phase      = ($urandom_range(0, 5) == 0) ? bnd[$urandom_range(0, 4)] : $urandom;
            cord_done  = (launch_q.size() > 0) && (launch_q[0] <= cyc);
            if (cord_done) begin
                void'(launch_q.pop_front());
                x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                y = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                cord_out_x = x;
                cord_out_y = y;
            end
            #1;
            er = cord_ready && (cnt != 64);
            vectors++;
            if (in_ready !== er) begin
                miscompares++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, in_ready, er);
            end
            acc = in_valid && er;
            pp  = cord_done && (cnt != 0);
            if (pp) begin
                pq = tag_q.pop_front();
                m_rot(int'(pq), x, y, c, s);
            end
            if (acc) begin
                tag_q.push_back(2'(m_quad(phase)));
                exp_ang = m_angle(phase);
                issued++;
            end
            cnt = cnt + int'(acc) - int'(pp);
            tick;
            cyc++;
            vectors++;
            if (cord_start !== acc || (acc && cord_angle !== exp_ang)) begin
                miscompares++;
                $display("FAIL rand_launch cyc %0d start=%b ang=%h want start=%b ang=%h", cyc, cord_start, cord_angle, acc, exp_ang);
            end
            if (cord_start === 1'b1) begin
                t = cyc + $urandom_range(0, 3);
                if (t < last_rdy) t = last_rdy;
                last_rdy = t;
                launch_q.push_back(t);
            end
            vectors++;
            if (out_valid !== pp || (pp && (out_cos !== c || out_sin !== s || out_quadrant !== pq))) begin
                miscompares++;
                $display("FAIL rand_result cyc %0d v=%b q=%0d %h/%h want v=%b q=%0d %h/%h",
                         cyc, out_valid, out_quadrant, out_cos, out_sin, pp, pq, c, s);
            end
            if (pp) popped++;
        end
        in_valid = 1'b0; cord_done = 1'b0; cord_ready = 1'b1;
        vectors++;
        if (popped != 300 || tag_err !== 1'b0) begin
            miscompares++; $display("FAIL rand_complete results %0d err=%b want 300 err=0", popped, tag_err);
        end
        tick;
    endtask

    task automatic test_reset_midflight;
        logic [31:0] ph[4];
        logic        rdy, st, st2, ov, ov2;
        logic [31:0] ang, oc, os, oc2;
        logic [1:0]  oq;
        ph = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        cord_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            phase    = ph[i % 4];
            tick;
        end
        in_valid = 1'b0;
        cord_done = 1'b1; cord_out_x = 32'h4000_0000; cord_out_y = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (out_valid !== 1'b1 || out_quadrant !== 2'(i)) begin
                miscompares++; $display("FAIL mid_order[%0d] valid/q got %b/%0d want 1/%0d", i, out_valid, out_quadrant, i);
            end
        end
        cord_done = 1'b0;
        reset = 1'b1; in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset in_ready got %b want 0", in_ready);
        end
        tick;
        tick;
        vectors++;
        if ({cord_start, cord_angle, out_valid, out_cos, out_sin, out_quadrant, tag_err} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs start=%b ang=%h ov=%b cos=%h sin=%h q=%0d err=%b want all 0",
                     cord_start, cord_angle, out_valid, out_cos, out_sin, out_quadrant, tag_err);
        end
        reset = 1'b0; in_valid = 1'b0;
        tick;
        run_one(32'h4000_0000, 32'h7FFF_0000, 32'h0, rdy, st, ang, st2, ov, oc, os, oq, ov2, oc2);
        vectors++;
        if (rdy !== 1'b1 || ov !== 1'b1 || oq !== 2'd1 || oc !== 32'h0 || os !== 32'h7FFF_0000) begin
            miscompares++;
            $display("FAIL post_reset_req rdy=%b v=%b q=%0d %h/%h want 1 1 1 00000000/7fff0000", rdy, ov, oq, oc, os);
        end
        cord_done = 1'b1;
        tick;
        cord_done = 1'b0;
        vectors++;
        if (tag_err !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_empty err/valid got %b/%b want 1/0", tag_err, out_valid);
        end
        do_reset;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; phase = '0; cord_ready = 1'b0;
        cord_out_x = '0; cord_out_y = '0; cord_done = 1'b0;
        test_reset;
        test_quadrants;
        test_boundaries;
        test_fifo_full;
        test_tag_err;
        test_random;
        test_reset_midflight;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cordic_phase_frontend.md
Name: cordic_phase_frontend

Overview:
- Full-circle sine/cosine wrapper logic placed around the pipelined CORDIC rotator.
- Front side accepts an unsigned full-turn phase. It rounds the phase to the nearest quadrant axis and launches the rotator with a residual angle in [-pi/4, pi/4), in_x=K and in_y=0.
- Back side consumes rotator results in order. It applies the quadrant rotation (swap/negate, saturating) using a tag FIFO and emits registered cos/sin.

Parameters:
- BIT_WIDTH, 32, data/phase width; must match the rotator.
- K, 32'sd1304052707, gain-compensated start x driven on cord_x.
- TAG_DEPTH, 64, tag FIFO entries (power of 2, >= rotator latency BIT_WIDTH+1).
- LOG2_TAG_DEPTH, 6, log2(TAG_DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  phase request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- phase  in  BIT_WIDTH  unsigned phase; 2^BIT_WIDTH = 2*pi
- cord_start  out  1  launch pulse to rotator start
- cord_angle  out  BIT_WIDTH  signed residual to rotator; 2^(BIT_WIDTH-2) = pi/4
- cord_x  out  BIT_WIDTH  constant K
- cord_y  out  BIT_WIDTH  constant 0
- cord_ready  in  1  rotator ready
- cord_out_x  in  BIT_WIDTH  rotator x result (cos of residual)
- cord_out_y  in  BIT_WIDTH  rotator y result (sin of residual)
- cord_done  in  1  one result per cycle it is high
- out_valid  out  1  result pulse
- out_cos  out  BIT_WIDTH  signed cos(phase)
- out_sin  out  BIT_WIDTH  signed sin(phase)
- out_quadrant  out  2  quadrant tag of the emitted result
- tag_err  out  1  sticky: cord_done seen with empty tag FIFO

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values:
  - cord_start=0, cord_angle=0, out_valid=0, out_cos=0, out_sin=0, out_quadrant=0, tag_err=0.
  - FIFO pointers and count cleared.
  - cord_x=K and cord_y=0 always (combinational constants).
- Ready: in_ready = ~reset & cord_ready & (count != TAG_DEPTH). It is combinational on registered state only; a same-cycle pop does not raise it.
- Range reduction on accept (cycle n):
  - q = (phase + 2^(BIT_WIDTH-3)) >> (BIT_WIDTH-2), computed modulo 2^BIT_WIDTH, 2 bits.
  - r = phase - q*2^(BIT_WIDTH-2), modulo 2^BIT_WIDTH, read signed; r is in [-2^(BIT_WIDTH-3), 2^(BIT_WIDTH-3)).
  - cord_angle <= r <<< 1.
  - Exactly +pi/4 rounds up to the next quadrant with residual -pi/4.
- Launch: cord_start is registered, high for exactly cycle n+1 per accepted request; zero launches on idle cycles. q is pushed into the tag FIFO at cycle n.
- Result path, cycle m with cord_done=1 and count != 0:
  - Pop q; register outputs; out_valid=1 in cycle m+1.
  - With c=cord_out_x and s=cord_out_y:
    - q=0: (cos,sin)=(c,s)
    - q=1: (-s,c)
    - q=2: (-c,-s)
    - q=3: (s,-c)
  - Negation saturates: -(-2^(BIT_WIDTH-1)) yields 2^(BIT_WIDTH-1)-1.
  - out_quadrant=q.
- Holding and ordering: out_cos, out_sin and out_quadrant hold between pulses. Results are strictly in acceptance order. There is no output backpressure.
- cord_done with count==0: no pop, out_valid=0, tag_err set; it is cleared only by reset.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo TAG_DEPTH.
- Reset mid-operation: all in-flight tags are discarded. The rotator is reset by the same reset, so no stale done is expected; any stale done sets tag_err.
- Throughput: 1 request/cycle while in_ready. End-to-end latency is 1 + rotator latency + 1 cycles.

Test Plan:
- Phase 0x00000000 -> cord_start at n+1, cord_angle=0, cord_x=K, cord_y=0; answer cord_out (0x7FFF0000, 0x00000000) -> out_valid next cycle, out_cos=0x7FFF0000, out_sin=0, out_quadrant=0.
- Phase 0x40000000 -> cord_angle=0; answer (0x7FFF0000, 0) -> out_cos=0, out_sin=0x7FFF0000, out_quadrant=1.
- Boundaries:
  - 0x20000000 -> q=1, cord_angle=0xC0000000.
  - 0xE0000000 -> q=0, cord_angle=0xC0000000.
  - 0xFFFFFFFF -> q=0, cord_angle=0xFFFFFFFE.
- Phase 0x80000000 with answer x=0x80000000, y=0x00001234 -> out_cos=0x7FFFFFFF (saturated), out_sin=0xFFFFEDCC, out_quadrant=2.
- FIFO full and errors:
  - Hold cord_done=0 and issue 64 requests -> in_ready=0 after the 64th.
  - One cord_done -> pop, in_ready=1 next cycle.
  - Push and pop in the same cycle -> count steady.
  - cord_done with empty FIFO -> tag_err=1, no out_valid.
- Back-to-back 8 requests at quadrants 0,1,2,3,0,1,2,3 with reset asserted mid-flight -> all outputs 0, in_ready=0 during reset, tag_err=0, count=0 afterwards; the next request completes normally.
